// File: rtl/next_tx_pkg.sv
// ---------------------------------------------------------------------------
// next_tx_pkg
// Shared definitions for the upstream transmit scheduler: packet opcodes,
// packet width, scheduler state encoding, requester channel encoding, and a
// helper that assembles a packet from opcode and payload.
// ---------------------------------------------------------------------------
package next_tx_pkg;

  localparam int OP_W      = 8;
  localparam int PAYLOAD_W = 32;
  localparam int PKT_W     = OP_W + PAYLOAD_W;

  localparam logic [OP_W-1:0] OP_POWER_ON = 8'hC7;
  localparam logic [OP_W-1:0] OP_KBD      = 8'hC5;
  localparam logic [OP_W-1:0] OP_MOUSE    = 8'hC6;
  localparam logic [OP_W-1:0] OP_MIC      = 8'hC3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic {
    CH_KBD = 1'b0,
    CH_MIC = 1'b1
  } channel_t;

  // Packet layout seen by the Sender: opcode in the top byte, payload below.
  function automatic logic [PKT_W-1:0] make_packet(
    input logic [OP_W-1:0]      op,
    input logic [PAYLOAD_W-1:0] payload
  );
    return {op, payload};
  endfunction

endpackage

// File: rtl/next_tx_rr2.sv
// ---------------------------------------------------------------------------
// next_tx_rr2
// Two-way round-robin pick between the keyboard/mouse and microphone
// requesters. The pick is purely combinational; the history register rr_last
// only advances when the caller reports that the pick was actually granted.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (rr_last -> CH_MIC)
//   req_kbd  in   keyboard/mouse request level
//   req_mic  in   microphone request level
//   update   in   pick was granted this cycle; remember it as rr_last
//   pick     out  channel chosen among the current requests
//   any      out  at least one request present
// ---------------------------------------------------------------------------
module next_tx_rr2
  import next_tx_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req_kbd,
  input  logic     req_mic,
  input  logic     update,
  output channel_t pick,
  output logic     any
);

  channel_t rr_last;

  // With both requesting, the channel that did not win last time goes next.
  always_comb begin
    any  = req_kbd | req_mic;
    pick = CH_KBD;
    if (req_kbd && req_mic) begin
      if (rr_last == CH_KBD) begin
        pick = CH_MIC;
      end else begin
        pick = CH_KBD;
      end
    end else if (req_mic) begin
      pick = CH_MIC;
    end
  end

  // Reset to CH_MIC so the keyboard wins the first contested round.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= CH_MIC;
    end else if (update) begin
      rr_last <= pick;
    end
  end

endmodule

// File: rtl/next_tx_scheduler.sv
// ---------------------------------------------------------------------------
// next_tx_scheduler
// Sequences upstream packets toward the serial Sender. Arbitrates between a
// latched power-on request, the keyboard/mouse word and the microphone
// sample, formats the winner into a 40-bit packet and holds it until the
// Sender takes it, then enforces an idle gap before the next grant. A mic
// sample that waits too long without a grant is dropped and counted.
//
// Ports:
//   mon_clk         in   single clock
//   hw_reset        in   synchronous active-high reset
//   power_on_req    in   single-cycle pulse, latched until served
//   kbd_valid       in   keyboard/mouse word pending (level)
//   kbd_is_mouse    in   selects the mouse opcode
//   kbd_data        in   16-bit key/mouse word
//   kbd_retrieved   out  pulse in the cycle the keyboard word is granted
//   mic_valid       in   mic sample pending (level)
//   mic_data        in   32-bit mic sample
//   mic_retrieved   out  pulse when the sample is granted or dropped
//   out_data        out  {opcode[7:0], payload[31:0]}
//   out_valid       out  packet available to the Sender
//   out_retrieved   in   Sender consumed out_data (pulse)
//   mic_drop_count  out  saturating count of timed-out mic samples
//   busy            out  high whenever not IDLE
// ---------------------------------------------------------------------------
module next_tx_scheduler
  import next_tx_pkg::*;
#(
  parameter int GAP_CYCLES  = 4,
  parameter int MIC_TIMEOUT = 2048,
  parameter int DROP_W      = 8
) (
  input  logic              mon_clk,
  input  logic              hw_reset,
  input  logic              power_on_req,
  input  logic              kbd_valid,
  input  logic              kbd_is_mouse,
  input  logic [15:0]       kbd_data,
  output logic              kbd_retrieved,
  input  logic              mic_valid,
  input  logic [31:0]       mic_data,
  output logic              mic_retrieved,
  output logic [PKT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_retrieved,
  output logic [DROP_W-1:0] mic_drop_count,
  output logic              busy
);

  // Counter widths sized so the terminal value always fits, with a floor of
  // one bit for the degenerate small-parameter cases.
  localparam int AGE_W = (MIC_TIMEOUT > 2) ? $clog2(MIC_TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [AGE_W-1:0] AGE_LAST =
    AGE_W'((MIC_TIMEOUT > 0) ? MIC_TIMEOUT - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state;
  state_t            state_nxt;

  logic              po_latch;
  logic              po_pending;
  logic              grant;
  logic              po_grant;
  logic              ch_grant;
  logic              kbd_grant;
  logic              mic_grant;
  logic              mic_drop;

  channel_t          rr_pick;
  logic              rr_any;

  logic [AGE_W-1:0]  age;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic [PKT_W-1:0]  pkt_q;
  logic [PKT_W-1:0]  pkt_nxt;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  next_tx_rr2 u_rr2 (
    .clk     (mon_clk),
    .rst     (hw_reset),
    .req_kbd (kbd_valid),
    .req_mic (mic_valid),
    .update  (ch_grant),
    .pick    (rr_pick),
    .any     (rr_any)
  );

  // A power-on pulse arriving while IDLE is served in that same cycle, so
  // the live request is merged with the latched one.
  assign po_pending = po_latch | power_on_req;

  // Grants are suppressed during reset so no retrieved pulse escapes while
  // the held packet is being discarded.
  assign grant     = (state == IDLE) && !hw_reset && (po_pending || rr_any);
  assign po_grant  = grant && po_pending;
  assign ch_grant  = grant && !po_pending;
  assign kbd_grant = ch_grant && (rr_pick == CH_KBD);
  assign mic_grant = ch_grant && (rr_pick == CH_MIC);

  // A mic grant in the terminal-age cycle takes precedence over the drop.
  assign mic_drop  = !hw_reset && mic_valid && !mic_grant && (age == AGE_LAST);

  always_comb begin
    pkt_nxt = make_packet(OP_POWER_ON, 32'h0);
    if (!po_pending) begin
      if (rr_pick == CH_MIC) begin
        pkt_nxt = make_packet(OP_MIC, mic_data);
      end else if (kbd_is_mouse) begin
        pkt_nxt = make_packet(OP_MOUSE, {16'h0, kbd_data});
      end else begin
        pkt_nxt = make_packet(OP_KBD, {16'h0, kbd_data});
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge mon_clk) begin
    if (hw_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_retrieved) begin
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid     = (state == HOLD);
    busy          = (state != IDLE);
    kbd_retrieved = kbd_grant;
    mic_retrieved = mic_grant | mic_drop;
  end

  assign out_data       = pkt_q;
  assign mic_drop_count = drop_cnt;

  // -------------------------------------------------------------------------
  // Held packet, power-on latch, mic aging, gap timer, drop counter
  // -------------------------------------------------------------------------
  always_ff @(posedge mon_clk) begin
    if (hw_reset) begin
      po_latch <= 1'b0;
      pkt_q    <= '0;
      age      <= '0;
      gap_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      // Pulses that land in the power-on grant cycle fold into that packet.
      po_latch <= po_pending & ~po_grant;

      if (grant) begin
        pkt_q <= pkt_nxt;
      end

      if (!mic_valid || mic_grant || mic_drop) begin
        age <= '0;
      end else begin
        age <= age + 1'b1;
      end

      // Cleared outside GAP so every gap starts counting from zero.
      if (state != GAP) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (mic_drop && (drop_cnt != {DROP_W{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_next_tx_scheduler.sv
module tb_next_tx_scheduler;
  import next_tx_pkg::*;

  logic        clk = 1'b0;
  logic        hw_reset = 1'b1;

  // Default-parameter instance
  logic        power_on_req = 1'b0;
  logic        kbd_valid = 1'b0;
  logic        kbd_is_mouse = 1'b0;
  logic [15:0] kbd_data = '0;
  logic        kbd_retrieved;
  logic        mic_valid = 1'b0;
  logic [31:0] mic_data = '0;
  logic        mic_retrieved;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_retrieved = 1'b0;
  logic [7:0]  mic_drop_count;
  logic        busy;

  // Small instance: no gap, short timeout, 2-bit drop counter
  logic        b_power_on_req = 1'b0;
  logic        b_kbd_valid = 1'b0;
  logic        b_kbd_is_mouse = 1'b0;
  logic [15:0] b_kbd_data = '0;
  logic        b_kbd_retrieved;
  logic        b_mic_valid = 1'b0;
  logic [31:0] b_mic_data = '0;
  logic        b_mic_retrieved;
  logic [39:0] b_out_data;
  logic        b_out_valid;
  logic        b_out_retrieved = 1'b0;
  logic [1:0]  b_mic_drop_count;
  logic        b_busy;

  localparam int GAP = 4;
  localparam int TMO = 2048;
  localparam int B_TMO = 16;

  int checks = 0;
  int failures = 0;
  int kbd_rt_cnt = 0;
  int mic_rt_cnt = 0;
  int b_mic_rt_cnt = 0;
  logic [39:0] sb_q[$];

  always #5 clk = ~clk;

  next_tx_scheduler #(.GAP_CYCLES(GAP), .MIC_TIMEOUT(TMO), .DROP_W(8)) dut (
    .mon_clk(clk), .hw_reset(hw_reset), .power_on_req(power_on_req),
    .kbd_valid(kbd_valid), .kbd_is_mouse(kbd_is_mouse), .kbd_data(kbd_data),
    .kbd_retrieved(kbd_retrieved), .mic_valid(mic_valid), .mic_data(mic_data),
    .mic_retrieved(mic_retrieved), .out_data(out_data), .out_valid(out_valid),
    .out_retrieved(out_retrieved), .mic_drop_count(mic_drop_count), .busy(busy)
  );

  next_tx_scheduler #(.GAP_CYCLES(0), .MIC_TIMEOUT(B_TMO), .DROP_W(2)) dut_s (
    .mon_clk(clk), .hw_reset(hw_reset), .power_on_req(b_power_on_req),
    .kbd_valid(b_kbd_valid), .kbd_is_mouse(b_kbd_is_mouse), .kbd_data(b_kbd_data),
    .kbd_retrieved(b_kbd_retrieved), .mic_valid(b_mic_valid), .mic_data(b_mic_data),
    .mic_retrieved(b_mic_retrieved), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_retrieved(b_out_retrieved), .mic_drop_count(b_mic_drop_count), .busy(b_busy)
  );

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (kbd_retrieved === 1'b1) kbd_rt_cnt <= kbd_rt_cnt + 1;
    if (mic_retrieved === 1'b1) mic_rt_cnt <= mic_rt_cnt + 1;
    if (b_mic_retrieved === 1'b1) b_mic_rt_cnt <= b_mic_rt_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    hw_reset = 1'b1;
    repeat (cycles) tick();
    hw_reset = 1'b0;
  endtask

  task automatic retrieve();
    out_retrieved = 1'b1;
    tick();
    out_retrieved = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Wait (bounded) for the next packet and compare it with the queue head.
  task automatic pop_check(input string tag);
    int n;
    logic [39:0] exp;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    if (sb_q.size() == 0) exp = 40'hx;
    else exp = sb_q.pop_front();
    chk(tag, out_data, exp);
  endtask

  initial begin
    int n;
    int k0;
    int m0;
    int bad;

    // Reset state
    do_reset(2);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 40'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", mic_drop_count, 8'h0);
    chk("rst_kbd_rt", kbd_retrieved, 1'b0);

    // Keyboard grant, then gap length
    k0 = kbd_rt_cnt;
    kbd_valid = 1'b1;
    kbd_data = 16'h0031;
    sb_q.push_back(40'hC5_0000_0031);
    #1;
    chk("kbd_rt_pulse", kbd_retrieved, 1'b1);
    tick();
    chk("kbd_latency", out_valid, 1'b1);
    pop_check("kbd_pkt");
    chk("kbd_rt_after", kbd_retrieved, 1'b0);
    kbd_data = 16'h0032;
    sb_q.push_back(40'hC5_0000_0032);
    retrieve();
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("gap_low_cycles", n, GAP + 1);
    pop_check("kbd_pkt2");
    kbd_valid = 1'b0;
    chk("kbd_rt_count", kbd_rt_cnt - k0, 2);
    retrieve();
    chk("valid_drop", out_valid, 1'b0);
    wait_idle("idle1");

    // Mouse opcode
    kbd_is_mouse = 1'b1;
    kbd_data = 16'h8102;
    kbd_valid = 1'b1;
    sb_q.push_back(40'hC6_0000_8102);
    tick();
    pop_check("mouse_pkt");
    kbd_valid = 1'b0;
    kbd_is_mouse = 1'b0;
    retrieve();
    wait_idle("idle2");

    // Priority and round-robin from reset
    do_reset(1);
    k0 = kbd_rt_cnt;
    m0 = mic_rt_cnt;
    power_on_req = 1'b1;
    kbd_valid = 1'b1;
    kbd_data = 16'h0041;
    mic_valid = 1'b1;
    mic_data = 32'h1234_5678;
    sb_q.push_back(40'hC7_0000_0000);
    sb_q.push_back(40'hC5_0000_0041);
    sb_q.push_back(40'hC3_1234_5678);
    #1;
    chk("po_no_kbd_rt", kbd_retrieved, 1'b0);
    chk("po_no_mic_rt", mic_retrieved, 1'b0);
    tick();
    power_on_req = 1'b0;
    pop_check("prio_po");
    retrieve();
    pop_check("prio_kbd");
    kbd_valid = 1'b0;
    retrieve();
    pop_check("prio_mic");
    mic_valid = 1'b0;
    retrieve();
    chk("prio_kbd_rt", kbd_rt_cnt - k0, 1);
    chk("prio_mic_rt", mic_rt_cnt - m0, 1);
    wait_idle("idle3");

    // Two power-on pulses during HOLD collapse into one packet
    kbd_valid = 1'b1;
    kbd_data = 16'h0055;
    sb_q.push_back(40'hC5_0000_0055);
    sb_q.push_back(40'hC7_0000_0000);
    tick();
    pop_check("merge_kbd");
    kbd_valid = 1'b0;
    power_on_req = 1'b1;
    tick();
    power_on_req = 1'b0;
    tick();
    power_on_req = 1'b1;
    tick();
    power_on_req = 1'b0;
    retrieve();
    pop_check("merge_po");
    retrieve();
    bad = 0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("merge_single", bad, 0);
    chk("merge_idle", busy, 1'b0);

    // Stalled Sender with a pending mic sample
    kbd_valid = 1'b1;
    kbd_data = 16'h0066;
    sb_q.push_back(40'hC5_0000_0066);
    tick();
    pop_check("stall_kbd");
    kbd_valid = 1'b0;
    chk("stall_drop0", mic_drop_count, 8'd0);
    m0 = mic_rt_cnt;
    mic_valid = 1'b1;
    mic_data = 32'hAABB_CCDD;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 40'hC5_0000_0066) bad++;
    end
    mic_valid = 1'b0;
    chk("stall_stable", bad, 0);
    chk("stall_drop_cnt", mic_drop_count, 8'd4);
    chk("stall_mic_rt", mic_rt_cnt - m0, 4);
    retrieve();
    wait_idle("idle4");

    // Reset while holding a packet with a power-on pending
    kbd_valid = 1'b1;
    kbd_data = 16'h0077;
    sb_q.push_back(40'hC5_0000_0077);
    tick();
    pop_check("rsthold_kbd");
    kbd_valid = 1'b0;
    power_on_req = 1'b1;
    tick();
    power_on_req = 1'b0;
    k0 = kbd_rt_cnt;
    m0 = mic_rt_cnt;
    hw_reset = 1'b1;
    tick();
    hw_reset = 1'b0;
    chk("rsthold_valid", out_valid, 1'b0);
    chk("rsthold_data", out_data, 40'h0);
    chk("rsthold_busy", busy, 1'b0);
    chk("rsthold_drop", mic_drop_count, 8'd0);
    bad = 0;
    repeat (12) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rsthold_po_cleared", bad, 0);
    chk("rsthold_no_rt", (kbd_rt_cnt - k0) + (mic_rt_cnt - m0), 0);

    // Small instance: drop-counter saturation, then zero-gap regrant
    b_kbd_valid = 1'b1;
    b_kbd_data = 16'h0099;
    tick();
    b_kbd_valid = 1'b0;
    chk("sat_hold_valid", b_out_valid, 1'b1);
    chk("sat_hold_data", b_out_data, 40'hC5_0000_0099);
    m0 = b_mic_rt_cnt;
    b_mic_valid = 1'b1;
    b_mic_data = 32'h0000_0001;
    repeat (90) tick();
    b_mic_valid = 1'b0;
    chk("sat_drop_cnt", b_mic_drop_count, 2'd3);
    chk("sat_mic_rt", b_mic_rt_cnt - m0, 5);
    b_mic_valid = 1'b1;
    b_mic_data = 32'hCAFE_F00D;
    b_out_retrieved = 1'b1;
    tick();
    b_out_retrieved = 1'b0;
    chk("nogap_valid_low", b_out_valid, 1'b0);
    chk("nogap_idle", b_busy, 1'b0);
    #1;
    chk("nogap_mic_grant", b_mic_retrieved, 1'b1);
    tick();
    b_mic_valid = 1'b0;
    chk("nogap_valid_high", b_out_valid, 1'b1);
    chk("nogap_data", b_out_data, 40'hC3_CAFE_F00D);
    chk("sat_drop_hold", b_mic_drop_count, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
